// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
// Optional feature macro: PC_COMPRESSED_EN (see pc_target_gen / pc_sequencer).
package pc_pkg;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JALR   = 2'd2,
        PC_RSVD   = 2'd3
    } pc_src_e;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_e;

    localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/pc_target_gen.sv
// Combinational next-PC target, link address and alignment check.
// PC_COMPRESSED_EN adds i_instr_len (16/32-bit step) and relaxes alignment to 2 bytes.
module pc_target_gen
    import pc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] i_pc,
    input  logic [1:0]            i_pc_src,
    input  logic [DATA_WIDTH-1:0] i_imm_op,
    input  logic [DATA_WIDTH-1:0] i_rs1_data,
`ifdef PC_COMPRESSED_EN
    input  logic                  i_instr_len,
`endif
    output logic [DATA_WIDTH-1:0] o_target,
    output logic [DATA_WIDTH-1:0] o_pc_plus,
    output logic                  o_misaligned
);

    logic [DATA_WIDTH-1:0] w_inc;
    logic [DATA_WIDTH-1:0] w_jalr_sum;

`ifdef PC_COMPRESSED_EN
    assign w_inc = i_instr_len ? DATA_WIDTH'(PC_INC) : DATA_WIDTH'(PC_INC / 2);
`else
    assign w_inc = DATA_WIDTH'(PC_INC);
`endif

    assign o_pc_plus  = i_pc + w_inc;
    assign w_jalr_sum = i_rs1_data + i_imm_op;

    always_comb begin
        o_target = o_pc_plus;
        case (pc_src_e'(i_pc_src))
            PC_BRANCH: o_target = i_pc + i_imm_op;
            PC_JALR:   o_target = {w_jalr_sum[DATA_WIDTH-1:1], 1'b0};
            default:   o_target = o_pc_plus;
        endcase
    end

`ifdef PC_COMPRESSED_EN
    assign o_misaligned = o_target[0];
`else
    assign o_misaligned = |o_target[1:0];
`endif

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC register with BOOT/RUN/HALT sequencing, valid/ready fetch and trap redirect.
// Macro PC_COMPRESSED_EN enables the i_instr_len port and 16-bit instruction support.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_stall,
    input  logic [1:0]            i_pc_src,
    input  logic [DATA_WIDTH-1:0] i_imm_op,
    input  logic [DATA_WIDTH-1:0] i_rs1_data,
    input  logic                  i_trap_take,
    input  logic [DATA_WIDTH-1:0] i_trap_vector,
    input  logic                  i_fetch_ready,
`ifdef PC_COMPRESSED_EN
    input  logic                  i_instr_len,
`endif
    output logic [DATA_WIDTH-1:0] o_pc,
    output logic [DATA_WIDTH-1:0] o_pc_plus,
    output logic                  o_fetch_valid,
    output logic                  o_misaligned,
    output logic [DATA_WIDTH-1:0] o_misaligned_addr
);

    pc_state_e             r_state;
    logic [DATA_WIDTH-1:0] r_pc;
    logic                  r_fetch_valid;
    logic                  r_misaligned;
    logic [DATA_WIDTH-1:0] r_misaligned_addr;

    logic [DATA_WIDTH-1:0] w_target;
    logic                  w_target_misaligned;

    pc_target_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_target_gen (
        .i_pc         (r_pc),
        .i_pc_src     (i_pc_src),
        .i_imm_op     (i_imm_op),
        .i_rs1_data   (i_rs1_data),
`ifdef PC_COMPRESSED_EN
        .i_instr_len  (i_instr_len),
`endif
        .o_target     (w_target),
        .o_pc_plus    (o_pc_plus),
        .o_misaligned (w_target_misaligned)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state           <= BOOT;
            r_pc              <= RESET_VECTOR;
            r_fetch_valid     <= 1'b0;
            r_misaligned      <= 1'b0;
            r_misaligned_addr <= '0;
        end else begin
            r_misaligned <= 1'b0;
            // Trap redirect overrides every state, stall and handshake.
            if (i_trap_take) begin
                r_pc          <= i_trap_vector;
                r_state       <= RUN;
                r_fetch_valid <= 1'b1;
            end else begin
                case (r_state)
                    BOOT: begin
                        r_state       <= RUN;
                        r_fetch_valid <= 1'b1;
                    end
                    RUN: begin
                        if (i_fetch_ready && !i_stall) begin
                            if (w_target_misaligned) begin
                                r_misaligned      <= 1'b1;
                                r_misaligned_addr <= w_target;
                                r_state           <= HALT;
                                r_fetch_valid     <= 1'b0;
                            end else begin
                                r_pc <= w_target;
                            end
                        end
                    end
                    HALT: begin
                        r_fetch_valid <= 1'b0;
                    end
                    default: begin
                        r_state       <= HALT;
                        r_fetch_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_pc              = r_pc;
    assign o_fetch_valid     = r_fetch_valid;
    assign o_misaligned      = r_misaligned;
    assign o_misaligned_addr = r_misaligned_addr;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (default build; PC_COMPRESSED_EN section optional).
module tb_pc_sequencer;

    localparam int unsigned DW = 32;

    logic          clk;
    logic          rst;
    logic          stall;
    logic [1:0]    pc_src;
    logic [DW-1:0] imm_op;
    logic [DW-1:0] rs1_data;
    logic          trap_take;
    logic [DW-1:0] trap_vector;
    logic          fetch_ready;
`ifdef PC_COMPRESSED_EN
    logic          instr_len;
`endif
    logic [DW-1:0] pc;
    logic [DW-1:0] pc_plus;
    logic          fetch_valid;
    logic          misaligned;
    logic [DW-1:0] misaligned_addr;

    int n_checks = 0;
    int n_errors = 0;

    pc_sequencer #(
        .DATA_WIDTH   (DW),
        .RESET_VECTOR (32'h0)
    ) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_stall           (stall),
        .i_pc_src          (pc_src),
        .i_imm_op          (imm_op),
        .i_rs1_data        (rs1_data),
        .i_trap_take       (trap_take),
        .i_trap_vector     (trap_vector),
        .i_fetch_ready     (fetch_ready),
`ifdef PC_COMPRESSED_EN
        .i_instr_len       (instr_len),
`endif
        .o_pc              (pc),
        .o_pc_plus         (pc_plus),
        .o_fetch_valid     (fetch_valid),
        .o_misaligned      (misaligned),
        .o_misaligned_addr (misaligned_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [DW-1:0] vec);
        trap_take   = 1'b1;
        trap_vector = vec;
        step();
        trap_take   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; pc_src = 2'd0; imm_op = '0; rs1_data = '0;
        trap_take = 1'b0; trap_vector = '0; fetch_ready = 1'b1;
`ifdef PC_COMPRESSED_EN
        instr_len = 1'b1;
`endif
        #2;
        check("rst_pc", pc, 32'h0);
        check("rst_valid", {31'b0, fetch_valid}, 32'h0);
        check("rst_mis", {31'b0, misaligned}, 32'h0);
        check("rst_maddr", misaligned_addr, 32'h0);
        rst = 1'b0;
        #1;
        check("boot_valid", {31'b0, fetch_valid}, 32'h0);
        step();
        check("run0_pc", pc, 32'h0);
        check("run0_valid", {31'b0, fetch_valid}, 32'h1);
        check("run0_pc_plus", pc_plus, 32'h4);
        step(); check("seq_4", pc, 32'h4);
        step(); check("seq_8", pc, 32'h8);
        step(); check("seq_12", pc, 32'hC);

        redirect(32'h100);
        check("trap_100", pc, 32'h100);
        pc_src = 2'd1; imm_op = 32'hFFFF_FFF0;
        step(); check("branch_neg", pc, 32'hF0);
        redirect(32'hFFFF_FFFC);
        pc_src = 2'd0;
        step(); check("seq_wrap", pc, 32'h0);
        pc_src = 2'd3;
        step(); check("rsvd_seq", pc, 32'h4);

        // Hold conditions then trap overriding stall.
        pc_src = 2'd1; imm_op = 32'h40; stall = 1'b1;
        step(); check("stall_hold", pc, 32'h4);
        stall = 1'b0; fetch_ready = 1'b0;
        step(); check("notready_hold", pc, 32'h4);
        check("notready_valid", {31'b0, fetch_valid}, 32'h1);
        fetch_ready = 1'b1;
        step(); check("branch_fwd", pc, 32'h44);
        stall = 1'b1;
        redirect(32'h200);
        check("trap_over_stall", pc, 32'h200);
        stall = 1'b0;

`ifndef PC_COMPRESSED_EN
        pc_src = 2'd2; rs1_data = 32'h203; imm_op = 32'h1;
        step(); check("jalr_clr", pc, 32'h204);
        rs1_data = 32'h201;
        step();
        check("mis_pc_hold", pc, 32'h204);
        check("mis_pulse", {31'b0, misaligned}, 32'h1);
        check("mis_addr", misaligned_addr, 32'h202);
        check("mis_valid", {31'b0, fetch_valid}, 32'h0);
        step();
        check("mis_pulse_end", {31'b0, misaligned}, 32'h0);
        check("mis_addr_held", misaligned_addr, 32'h202);
        stall = 1'b1; fetch_ready = 1'b0; pc_src = 2'd0;
        step();
        stall = 1'b0; fetch_ready = 1'b1; pc_src = 2'd1; imm_op = 32'h4;
        step();
        check("halt_pc", pc, 32'h204);
        check("halt_valid", {31'b0, fetch_valid}, 32'h0);
        redirect(32'h80);
        check("halt_exit_pc", pc, 32'h80);
        check("halt_exit_valid", {31'b0, fetch_valid}, 32'h1);
        pc_src = 2'd1; imm_op = 32'h2;
        step();
        check("branch_mis_pc", pc, 32'h80);
        check("branch_mis_addr", misaligned_addr, 32'h82);
`else
        redirect(32'h10);
        pc_src = 2'd0; instr_len = 1'b0;
        check("c_pc_plus", pc_plus, 32'h12);
        step(); check("c_seq16", pc, 32'h12);
        instr_len = 1'b1;
        redirect(32'h100);
        pc_src = 2'd1; imm_op = 32'h2;
        step(); check("c_branch_ok", pc, 32'h102);
        imm_op = 32'hFFFF_FFFF;
        step();
        check("c_mis_pc", pc, 32'h102);
        check("c_mis_pulse", {31'b0, misaligned}, 32'h1);
        check("c_mis_addr", misaligned_addr, 32'h101);
        redirect(32'h80);
        check("c_exit", pc, 32'h80);
`endif

        // Asynchronous reset mid-cycle, then trap taken during BOOT.
        pc_src = 2'd0;
        #3 rst = 1'b1;
        #1;
        check("async_rst_pc", pc, 32'h0);
        check("async_rst_valid", {31'b0, fetch_valid}, 32'h0);
        rst = 1'b0;
        redirect(32'h300);
        check("boot_trap_pc", pc, 32'h300);
        check("boot_trap_valid", {31'b0, fetch_valid}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter register and next-PC sequencer for the RISC-V core's fetch stage. It holds the architectural PC, selects the next PC (sequential, branch, JALR or trap vector) and presents fetch requests to instruction memory through a valid/ready handshake. It flags misaligned control-flow targets and halts fetch until a trap redirect. It replaces the bare PC adder, adding stall, handshake, trap and alignment behaviour.

## Interface
- `DATA_WIDTH`, 32, PC/address width (≥ 8)
- `RESET_VECTOR`, 0, PC value loaded on reset
- `clk` input 1 — core clock
- `rst` input 1 — asynchronous, active-high reset
- `stall` input 1 — hold PC (hazard/back-pressure from decode)
- `pc_src` input 2 — next-PC mode: 0 SEQ, 1 BRANCH, 2 JALR, 3 reserved (treated as SEQ)
- `imm_op` input DATA_WIDTH — sign-extended immediate
- `rs1_data` input DATA_WIDTH — JALR base register
- `trap_take` input 1 — redirect to trap vector
- `trap_vector` input DATA_WIDTH — trap target
- `fetch_ready` input 1 — instruction memory accepts request
- `instr_len` input 1 — only with `PC_COMPRESSED_EN`: 1 = 32-bit instruction, 0 = 16-bit
- `pc` output DATA_WIDTH — current PC / fetch address
- `pc_plus` output DATA_WIDTH — link address (pc + instruction length), combinational
- `fetch_valid` output 1 — fetch request valid
- `misaligned` output 1 — one-cycle pulse on misaligned target
- `misaligned_addr` output DATA_WIDTH — offending target, held until next pulse

## Operation
- States: BOOT, RUN, HALT.
- Reset (async): state=BOOT, pc=RESET_VECTOR, fetch_valid=0, misaligned=0, misaligned_addr=0.
- BOOT: lasts one cycle after reset release → RUN; pc unchanged. trap_take in BOOT → pc=trap_vector, → RUN.
- RUN: fetch_valid=1. Advance when `fetch_ready && !stall`.
- Targets, all modulo 2^DATA_WIDTH, wrap silently: SEQ = pc+4; BRANCH = pc+imm_op; JALR = (rs1_data+imm_op) & ~1.
- Alignment: target[1:0] must be 00; otherwise pc holds, misaligned pulses, misaligned_addr = target, → HALT.
- HALT: fetch_valid=0; pc holds; stall, fetch_ready and pc_src ignored; only trap_take leaves HALT.
- Priority: rst > trap_take > hold (stall or !fetch_ready) > pc_src. trap_take in any state loads pc=trap_vector unconditionally (ignores stall/fetch_ready), state → RUN. A misaligned trap_vector is not checked.
- pc_plus = pc+4 (or per instr_len with macro).

## Timing
- pc, state, fetch_valid, misaligned, misaligned_addr are registered; update on posedge clk.
- Redirect latency: one cycle, sampled in cycle N → new pc visible in N+1.
- Handshake: request transfers when fetch_valid && fetch_ready at a clock edge; pc stable while fetch_valid && !fetch_ready.
- misaligned high exactly one cycle, in the cycle after the offending edge, coincident with entering HALT.
- Reset mid-operation: outputs return to reset values immediately, independent of clk.

## Configuration
- `PC_COMPRESSED_EN` defined: `instr_len` port present; SEQ = pc + (instr_len ? 4 : 2); pc_plus likewise; alignment requires target[0]=0 only.
- Undefined: no instr_len; SEQ/pc_plus = pc+4; alignment requires target[1:0]=00.

## Structure
- Package `pc_pkg`: `pc_src_e` enum (PC_SEQ, PC_BRANCH, PC_JALR, PC_RSVD), `pc_state_e` (BOOT, RUN, HALT), constant `PC_INC = 4`.
- One sub-module: `pc_target_gen` — combinational target computation and alignment check; FSM and registers stay in `pc_sequencer`.

## Test plan
- Reset, release, fetch_ready=1, pc_src=SEQ → pc 0 for BOOT + first RUN cycle, then 4, 8, 12; fetch_valid 0 in BOOT then 1.
- pc=0x100, BRANCH, imm_op=0xFFFFFFF0 → pc=0xF0 next cycle; pc=0xFFFFFFFC SEQ → wraps to 0.
- JALR rs1_data=0x203, imm_op=1 → pc=0x204; rs1_data=0x201, imm_op=1 → target 0x202 misaligned: pulse, misaligned_addr=0x202, pc holds, fetch_valid=0.
- In HALT toggle stall/fetch_ready/pc_src → pc unchanged; trap_take with trap_vector=0x80 → pc=0x80, fetch_valid=1.
- stall=1 or fetch_ready=0 with BRANCH → pc holds; trap_take asserted simultaneously with stall=1 → pc=trap_vector.
- `PC_COMPRESSED_EN`: instr_len=0 from pc=0x10 → 0x12; BRANCH to 0x102 → accepted; target 0x101 → misaligned.
